// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder
// Description : Memory-side responder for the accelerator SRAM port. Holds
//               DEPTH words, answers accelerator reads after a fixed RD_LAT
//               cycle latency (no valid strobe on that port) and serves a
//               secondary host port whenever the accelerator is idle.
// Ports       : clk, rst                   - clock / synchronous active-high reset
//               acc_addr/rd_en/wr_en/wdata - accelerator request
//               acc_rdata                  - accelerator read data (registered)
//               host_req/we/addr/wdata     - host request (held until granted)
//               host_gnt                   - host served this cycle (combinational)
//               host_rdata/host_rvalid     - host read data + one-cycle strobe
//               err_clr                    - clears the sticky error flags
//               oob_err/conflict_err       - sticky error flags
//               acc_rd_cnt/acc_wr_cnt      - accepted accelerator strobes (wrap)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1     // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic              acc_rd_en,
    input  logic              acc_wr_en,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic [DATA_W-1:0] acc_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              err_clr,
    output logic              oob_err,
    output logic              conflict_err,
    output logic [31:0]       acc_rd_cnt,
    output logic [31:0]       acc_wr_cnt
);

    localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_acc_oob;
    logic               w_host_oob;
    logic [c_IDX_W-1:0] w_acc_idx;
    logic [c_IDX_W-1:0] w_host_idx;
    logic               w_host_gnt;
    logic               w_host_rd;
    logic               w_host_wr;
    logic               w_oob_evt;
    logic               w_conflict_evt;
    logic [DATA_W-1:0]  w_acc_rd_data;
    logic [DATA_W-1:0]  w_host_rd_data;

    logic [DATA_W-1:0]  r_acc_rdata;
    logic [DATA_W-1:0]  r_host_rdata;
    logic               r_host_rvalid;
    logic               r_oob_err;
    logic               r_conflict_err;
    logic [31:0]        r_acc_rd_cnt;
    logic [31:0]        r_acc_wr_cnt;

    // ------------------------------------------------------------------------
    // Address decode and arbitration (accelerator always wins)
    // ------------------------------------------------------------------------
    assign w_acc_oob  = ({1'b0, acc_addr}  >= c_DEPTH);
    assign w_host_oob = ({1'b0, host_addr} >= c_DEPTH);
    assign w_acc_idx  = acc_addr[c_IDX_W-1:0];
    assign w_host_idx = host_addr[c_IDX_W-1:0];

    assign w_host_gnt = host_req & ~acc_rd_en & ~acc_wr_en;
    assign w_host_rd  = w_host_gnt & ~host_we;
    assign w_host_wr  = w_host_gnt &  host_we;

    // Reads sample the array before this edge's write lands, so a combined
    // read+write to one address returns the old word.
    assign w_acc_rd_data  = w_acc_oob  ? '0 : r_mem[w_acc_idx];
    assign w_host_rd_data = w_host_oob ? '0 : r_mem[w_host_idx];

    assign w_oob_evt      = ((acc_rd_en | acc_wr_en) & w_acc_oob) | (w_host_gnt & w_host_oob);
    assign w_conflict_evt = acc_rd_en & acc_wr_en;

    // ------------------------------------------------------------------------
    // Storage: single write port, never reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (acc_wr_en && !w_acc_oob) begin
            r_mem[w_acc_idx] <= acc_wdata;
        end else if (w_host_wr && !w_host_oob) begin
            r_mem[w_host_idx] <= host_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read pipelines. The output register is the last stage: it only loads
    // when a result arrives, so acc_rdata holds between reads.
    // ------------------------------------------------------------------------
    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst) begin
                r_acc_rdata   <= '0;
                r_host_rdata  <= '0;
                r_host_rvalid <= 1'b0;
            end else begin
                if (acc_rd_en) begin
                    r_acc_rdata <= w_acc_rd_data;
                end
                r_host_rvalid <= w_host_rd;
                if (w_host_rd) begin
                    r_host_rdata <= w_host_rd_data;
                end
            end
        end
    end else begin : g_latn
        logic              r_acc_vld  [RD_LAT-1];
        logic [DATA_W-1:0] r_acc_dat  [RD_LAT-1];
        logic              r_host_vld [RD_LAT-1];
        logic [DATA_W-1:0] r_host_dat [RD_LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                // Clearing the valid bits discards every in-flight read.
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    r_acc_vld[i]  <= 1'b0;
                    r_host_vld[i] <= 1'b0;
                end
                r_acc_rdata   <= '0;
                r_host_rdata  <= '0;
                r_host_rvalid <= 1'b0;
            end else begin
                r_acc_vld[0]  <= acc_rd_en;
                r_acc_dat[0]  <= w_acc_rd_data;
                r_host_vld[0] <= w_host_rd;
                r_host_dat[0] <= w_host_rd_data;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    r_acc_vld[i]  <= r_acc_vld[i-1];
                    r_acc_dat[i]  <= r_acc_dat[i-1];
                    r_host_vld[i] <= r_host_vld[i-1];
                    r_host_dat[i] <= r_host_dat[i-1];
                end
                if (r_acc_vld[RD_LAT-2]) begin
                    r_acc_rdata <= r_acc_dat[RD_LAT-2];
                end
                r_host_rvalid <= r_host_vld[RD_LAT-2];
                if (r_host_vld[RD_LAT-2]) begin
                    r_host_rdata <= r_host_dat[RD_LAT-2];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky errors (a new event beats a same-cycle clear) and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oob_err      <= 1'b0;
            r_conflict_err <= 1'b0;
            r_acc_rd_cnt   <= '0;
            r_acc_wr_cnt   <= '0;
        end else begin
            r_oob_err      <= (r_oob_err      & ~err_clr) | w_oob_evt;
            r_conflict_err <= (r_conflict_err & ~err_clr) | w_conflict_evt;
            if (acc_rd_en) begin
                r_acc_rd_cnt <= r_acc_rd_cnt + 32'd1;
            end
            if (acc_wr_en) begin
                r_acc_wr_cnt <= r_acc_wr_cnt + 32'd1;
            end
        end
    end

    assign acc_rdata    = r_acc_rdata;
    assign host_gnt     = w_host_gnt;
    assign host_rdata   = r_host_rdata;
    assign host_rvalid  = r_host_rvalid;
    assign oob_err      = r_oob_err;
    assign conflict_err = r_conflict_err;
    assign acc_rd_cnt   = r_acc_rd_cnt;
    assign acc_wr_cnt   = r_acc_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_responder
// Description : Scoreboard bench for sram_responder. Three instances with
//               RD_LAT = 1, 3 and 4 share one directed stimulus stream. The
//               stimulus task keeps a reference memory and pushes expected
//               read words; a monitor per instance pops them when a result is
//               due (acc port) or when host_rvalid is seen (host port).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] acc_addr = '0;
    logic        acc_rd_en = 1'b0;
    logic        acc_wr_en = 1'b0;
    logic [31:0] acc_wdata = '0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        err_clr = 1'b0;

    logic [31:0] acc_rdata_a   [3];
    logic [31:0] host_rdata_a  [3];
    logic [31:0] acc_rd_cnt_a  [3];
    logic [31:0] acc_wr_cnt_a  [3];
    logic        host_gnt_a    [3];
    logic        host_rvalid_a [3];
    logic        oob_a         [3];
    logic        conf_a        [3];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] mdl [1024];
    logic [31:0] exp_acc  [$];
    logic [31:0] exp_host [$];
    logic [31:0] m_rd  = '0;
    logic [31:0] m_wr  = '0;
    logic        m_oob = 1'b0;
    logic        m_conf = 1'b0;

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int lat, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (RD_LAT=%0d) at %0t: got %h, expected %h", nm, lat, $time, act, exp);
        end
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
        int          ap;
        int          hp;
        logic [31:0] last_a;
        bit          al [4];
        bit          hl [4];

        sram_responder #(
            .DATA_W (32),
            .ADDR_W (16),
            .DEPTH  (1024),
            .RD_LAT (L)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .acc_addr     (acc_addr),
            .acc_rd_en    (acc_rd_en),
            .acc_wr_en    (acc_wr_en),
            .acc_wdata    (acc_wdata),
            .acc_rdata    (acc_rdata_a[k]),
            .host_req     (host_req),
            .host_we      (host_we),
            .host_addr    (host_addr),
            .host_wdata   (host_wdata),
            .host_gnt     (host_gnt_a[k]),
            .host_rdata   (host_rdata_a[k]),
            .host_rvalid  (host_rvalid_a[k]),
            .err_clr      (err_clr),
            .oob_err      (oob_a[k]),
            .conflict_err (conf_a[k]),
            .acc_rd_cnt   (acc_rd_cnt_a[k]),
            .acc_wr_cnt   (acc_wr_cnt_a[k])
        );

        // Monitor: al/hl record which past edges issued a read; entry L-1 is
        // the read whose result becomes visible after the current edge.
        initial begin
            bit r_s, a_s, h_s;
            ap = 0;
            hp = 0;
            last_a = '0;
            for (int i = 0; i < 4; i++) begin
                al[i] = 1'b0;
                hl[i] = 1'b0;
            end
            forever begin
                @(posedge clk);
                r_s = rst;
                a_s = acc_rd_en;
                h_s = host_req & ~acc_rd_en & ~acc_wr_en & ~host_we;
                #1;
                for (int i = 3; i > 0; i--) begin
                    al[i] = al[i-1];
                    hl[i] = hl[i-1];
                end
                al[0] = a_s & ~r_s;
                hl[0] = h_s & ~r_s;
                if (r_s) begin
                    for (int i = 0; i < L; i++) begin
                        if (al[i]) ap++;
                        if (hl[i]) hp++;
                    end
                    for (int i = 0; i < 4; i++) begin
                        al[i] = 1'b0;
                        hl[i] = 1'b0;
                    end
                    last_a = '0;
                    chk("rst_acc_rdata", L, acc_rdata_a[k], 32'h0);
                    chk("rst_host_rdata", L, host_rdata_a[k], 32'h0);
                    chk("rst_host_rvalid", L, {31'b0, host_rvalid_a[k]}, 32'h0);
                end else begin
                    if (al[L-1]) begin
                        if (ap < exp_acc.size()) begin
                            last_a = exp_acc[ap];
                        end else begin
                            n_vec++;
                            n_fail++;
                            $display("FAIL acc_underflow (RD_LAT=%0d) at %0t: no expected word queued", L, $time);
                        end
                        ap++;
                    end
                    chk("acc_rdata", L, acc_rdata_a[k], last_a);
                    chk("host_rvalid", L, {31'b0, host_rvalid_a[k]}, {31'b0, hl[L-1]});
                    if (hl[L-1] && host_rvalid_a[k]) begin
                        if (hp < exp_host.size()) begin
                            chk("host_rdata", L, host_rdata_a[k], exp_host[hp]);
                        end else begin
                            n_vec++;
                            n_fail++;
                            $display("FAIL host_underflow (RD_LAT=%0d) at %0t: no expected word queued", L, $time);
                        end
                    end
                    if (hl[L-1]) hp++;
                end
            end
        end
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    // One clock cycle of stimulus: check registered state left by the last
    // edge, drive new inputs, check the combinational grant, then advance the
    // reference model by what the coming edge must do.
    task automatic step(input bit r, input bit rd, input bit wr, input int a,
                        input logic [31:0] wd, input bit hq, input bit hw,
                        input int ha, input logic [31:0] hwd, input bit clr);
        bit g;
        bit evt_o;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("acc_rd_cnt", lat_of(k), acc_rd_cnt_a[k], m_rd);
            chk("acc_wr_cnt", lat_of(k), acc_wr_cnt_a[k], m_wr);
            chk("oob_err", lat_of(k), {31'b0, oob_a[k]}, {31'b0, m_oob});
            chk("conflict_err", lat_of(k), {31'b0, conf_a[k]}, {31'b0, m_conf});
        end
        rst        = r;
        acc_rd_en  = rd;
        acc_wr_en  = wr;
        acc_addr   = 16'(a);
        acc_wdata  = wd;
        host_req   = hq;
        host_we    = hw;
        host_addr  = 16'(ha);
        host_wdata = hwd;
        err_clr    = clr;
        g = hq & ~rd & ~wr;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("host_gnt", lat_of(k), {31'b0, host_gnt_a[k]}, {31'b0, g});
        end
        if (r) begin
            m_rd   = '0;
            m_wr   = '0;
            m_oob  = 1'b0;
            m_conf = 1'b0;
        end else begin
            if (rd) exp_acc.push_back((a < 1024) ? mdl[a] : 32'h0);
            if (g && !hw) exp_host.push_back((ha < 1024) ? mdl[ha] : 32'h0);
            evt_o  = ((rd || wr) && a >= 1024) || (g && ha >= 1024);
            m_oob  = (m_oob & ~clr) | evt_o;
            m_conf = (m_conf & ~clr) | (rd & wr);
            if (wr && a < 1024) mdl[a] = wd;
            else if (g && hw && ha < 1024) mdl[ha] = hwd;
            if (rd) m_rd = m_rd + 32'd1;
            if (wr) m_wr = m_wr + 32'd1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic hwr(input int a, input logic [31:0] d);
        step(0, 0, 0, 0, 0, 1, 1, a, d, 0);
    endtask
    task automatic hrd(input int a);
        step(0, 0, 0, 0, 0, 1, 0, a, 0, 0);
    endtask
    task automatic ard(input int a);
        step(0, 1, 0, a, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic awr(input int a, input logic [31:0] d);
        step(0, 0, 1, a, d, 0, 0, 0, 0, 0);
    endtask
    task automatic clr_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Host preload, then back-to-back accelerator reads
        for (int i = 0; i < 4; i++) hwr(i, 32'(i + 1));
        hwr(5, 32'h55);
        hwr(7, 32'h11);
        for (int i = 0; i < 4; i++) ard(i);
        idle(5);

        // Single read, result must hold through idle cycles
        ard(2);
        idle(6);

        // Host read of addr 5 stalled by three accelerator reads
        for (int i = 0; i < 3; i++) step(0, 1, 0, i, 0, 1, 0, 5, 0, 0);
        hrd(5);
        idle(5);

        // Out-of-range accesses and error clear
        awr(1024, 32'hDEAD_BEEF);
        idle(2);
        ard(1024);
        ard(0);
        idle(5);
        clr_step();
        idle(1);
        hwr(1024, 32'hBAD0_0000);
        step(0, 0, 0, 0, 0, 1, 0, 2000, 0, 1);   // clear loses to a new error
        idle(1);
        clr_step();
        idle(2);

        // Read+write conflict on addr 7
        step(0, 1, 1, 7, 32'h22, 0, 0, 0, 0, 0);
        ard(7);
        idle(5);
        clr_step();

        // Back-to-back host reads, accelerator write then readback
        for (int i = 0; i < 4; i++) hrd(i);
        awr(9, 32'hCAFE_F00D);
        ard(9);
        hrd(9);
        idle(5);

        // Reset with reads in flight on both ports
        ard(3);
        hrd(1);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(8);

        chk("acc_drain", 1, 32'(g_dut[0].ap), 32'(exp_acc.size()));
        chk("acc_drain", 3, 32'(g_dut[1].ap), 32'(exp_acc.size()));
        chk("acc_drain", 4, 32'(g_dut[2].ap), 32'(exp_acc.size()));
        chk("host_drain", 1, 32'(g_dut[0].hp), 32'(exp_host.size()));
        chk("host_drain", 3, 32'(g_dut[1].hp), 32'(exp_host.size()));
        chk("host_drain", 4, 32'(g_dut[2].hp), 32'(exp_host.size()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
